oh_gpio_ctrl: RTL and testbench

Parametrised per-pin GPIO controller between core logic and the GPIO pad ring. Holds a 16-bit control word per pin, drives the pad-ring `dout`/`oen`/`ie`/`cfg` vectors, and synchronises and optionally debounces pad inputs. Also detects programmable edges, producing sticky, maskable interrupts. Adds open-drain mode, input filtering and interrupts beyond a plain pad wrapper.

---
 rtl/oh_gpio_pkg.sv | 51 +++++
 rtl/oh_gpio_filter.sv | 60 ++++++
 rtl/oh_gpio_ctrl.sv | 136 +++++++++++++
 tb/tb_oh_gpio_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/oh_gpio_pkg.sv
// Shared encodings and control-word layout for the GPIO controller.
package oh_gpio_pkg;

  typedef enum logic [1:0] {
    GPIO_DIS = 2'b00,
    GPIO_IN  = 2'b01,
    GPIO_PP  = 2'b10,
    GPIO_OD  = 2'b11
  } gpio_mode_e;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } gpio_edge_e;

  localparam int unsigned CtrlW    = 16;
  localparam int unsigned PadCfgW  = 8;
  localparam int unsigned PadCfgLsb = 0;
  localparam int unsigned ModeLsb  = 8;
  localparam int unsigned ModeW    = 2;
  localparam int unsigned EdgeLsb  = 10;
  localparam int unsigned EdgeW    = 2;
  localparam int unsigned DbenBit  = 12;
  localparam int unsigned MaskBit  = 13;

  // Reserved bits [15:14] are never stored.
  localparam logic [CtrlW-1:0] CtrlWrMask = 16'h3FFF;

  typedef struct packed {
    logic [1:0]           rsvd;
    logic                 mask;
    logic                 dben;
    gpio_edge_e           edge_sel;
    gpio_mode_e           mode;
    logic [PadCfgW-1:0]   pad_cfg;
  } gpio_ctrl_t;

  function automatic logic edge_hit(gpio_edge_e sel, logic rise, logic fall);
    logic hit;
    case (sel)
      EDGE_RISE: hit = rise;
      EDGE_FALL: hit = fall;
      EDGE_BOTH: hit = rise | fall;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/oh_gpio_filter.sv
// Per-pin input path: two-flop synchroniser, optional debounce and edge event.
module oh_gpio_filter
  import oh_gpio_pkg::*;
#(
  parameter int unsigned DBW      = 8,
  parameter int unsigned DBCYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       din_i,
  input  logic       dben_i,
  input  gpio_edge_e edge_sel_i,
  output logic       filt_o,
  output logic       evt_o
);

  localparam logic [DBW-1:0] DbLast = DBW'(DBCYCLES - 1);

  logic           s1_q, s2_q;
  logic           filt_d, filt_q;
  logic [DBW-1:0] cnt_d, cnt_q;
  logic           rise, fall;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= din_i;
      s2_q   <= s1_q;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  // Counter only runs while the synchronised value disagrees with filt.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (!dben_i) begin
      filt_d = s2_q;
    end else if (s2_q != filt_q) begin
      if (cnt_q == DbLast) begin
        filt_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    rise   = filt_d & ~filt_q;
    fall   = ~filt_d & filt_q;
    evt_o  = edge_hit(edge_sel_i, rise, fall);
    filt_o = filt_q;
  end

endmodule

// File: rtl/oh_gpio_ctrl.sv
// GPIO controller: per-pin control words, pad-ring drive, filtered inputs and edge interrupts.
module oh_gpio_ctrl
  import oh_gpio_pkg::*;
#(
  parameter int unsigned NGPIO    = 8,
  parameter int unsigned SW       = 6,
  parameter int unsigned DBW      = 8,
  parameter int unsigned DBCYCLES = 16
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 cfg_write,
  input  logic [SW-1:0]        cfg_sel,
  input  logic [15:0]          cfg_wdata,
  output logic [15:0]          cfg_rdata,
  input  logic [NGPIO-1:0]     gpio_out,
  output logic [NGPIO-1:0]     gpio_in,
  input  logic [NGPIO-1:0]     irq_clear,
  output logic [NGPIO-1:0]     irq_status,
  output logic                 irq,
  output logic [NGPIO-1:0]     pad_dout,
  output logic [NGPIO-1:0]     pad_oen,
  output logic [NGPIO-1:0]     pad_ie,
  output logic [NGPIO*8-1:0]   pad_cfg,
  input  logic [NGPIO-1:0]     pad_din
);

  gpio_ctrl_t       ctrl_d [NGPIO];
  gpio_ctrl_t       ctrl_q [NGPIO];
  logic [NGPIO-1:0] irq_mask;
  logic [NGPIO-1:0] edge_evt;
  logic [NGPIO-1:0] status_d, status_q;

  // Out-of-range selects match no pin, so writes drop and reads return 0.
  always_comb begin
    for (int unsigned i = 0; i < NGPIO; i++) begin
      ctrl_d[i] = ctrl_q[i];
      if (cfg_write && (cfg_sel == SW'(i))) begin
        ctrl_d[i] = gpio_ctrl_t'(cfg_wdata & CtrlWrMask);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      for (int unsigned i = 0; i < NGPIO; i++) begin
        ctrl_q[i] <= '0;
      end
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  always_comb begin
    cfg_rdata = '0;
    for (int unsigned i = 0; i < NGPIO; i++) begin
      if (cfg_sel == SW'(i)) begin
        cfg_rdata = ctrl_q[i];
      end
    end
  end

  always_comb begin
    pad_dout = '0;
    pad_oen  = '1;
    pad_ie   = '0;
    pad_cfg  = '0;
    irq_mask = '0;
    for (int unsigned i = 0; i < NGPIO; i++) begin
      pad_cfg[8*i +: 8] = ctrl_q[i].pad_cfg;
      irq_mask[i]       = ctrl_q[i].mask;
      unique case (ctrl_q[i].mode)
        GPIO_DIS: begin
          pad_oen[i]  = 1'b1;
          pad_dout[i] = 1'b0;
          pad_ie[i]   = 1'b0;
        end
        GPIO_IN: begin
          pad_oen[i]  = 1'b1;
          pad_dout[i] = 1'b0;
          pad_ie[i]   = 1'b1;
        end
        GPIO_PP: begin
          pad_oen[i]  = 1'b0;
          pad_dout[i] = gpio_out[i];
          pad_ie[i]   = 1'b1;
        end
        GPIO_OD: begin
          pad_oen[i]  = gpio_out[i];
          pad_dout[i] = 1'b0;
          pad_ie[i]   = 1'b1;
        end
        default: begin
          pad_oen[i]  = 1'b1;
          pad_dout[i] = 1'b0;
          pad_ie[i]   = 1'b0;
        end
      endcase
    end
  end

  // Input is gated by ie so disabled pins never propagate pad activity.
  for (genvar i = 0; i < NGPIO; i++) begin : g_pin
    oh_gpio_filter #(
      .DBW      (DBW),
      .DBCYCLES (DBCYCLES)
    ) u_filter (
      .clk_i      (clk),
      .rst_ni     (nreset),
      .din_i      (pad_din[i] & pad_ie[i]),
      .dben_i     (ctrl_q[i].dben),
      .edge_sel_i (ctrl_q[i].edge_sel),
      .filt_o     (gpio_in[i]),
      .evt_o      (edge_evt[i])
    );
  end

  // Set wins over a simultaneous clear.
  always_comb begin
    status_d = (status_q & ~irq_clear) | edge_evt;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      status_q <= '0;
    end else begin
      status_q <= status_d;
    end
  end

  always_comb begin
    irq_status = status_q;
    irq        = |(status_q & irq_mask);
  end

endmodule

// File: tb/tb_oh_gpio_ctrl.sv
// Directed bench for oh_gpio_ctrl with immediate-assertion checks.
module tb_oh_gpio_ctrl;

  localparam int unsigned NGPIO = 8;
  localparam int unsigned SW    = 6;

  logic               clk;
  logic               nreset;
  logic               cfg_write;
  logic [SW-1:0]      cfg_sel;
  logic [15:0]        cfg_wdata;
  logic [15:0]        cfg_rdata;
  logic [NGPIO-1:0]   gpio_out;
  logic [NGPIO-1:0]   gpio_in;
  logic [NGPIO-1:0]   irq_clear;
  logic [NGPIO-1:0]   irq_status;
  logic               irq;
  logic [NGPIO-1:0]   pad_dout;
  logic [NGPIO-1:0]   pad_oen;
  logic [NGPIO-1:0]   pad_ie;
  logic [NGPIO*8-1:0] pad_cfg;
  logic [NGPIO-1:0]   pad_din;

  int n_vec;
  int n_err;

  oh_gpio_ctrl #(
    .NGPIO    (NGPIO),
    .SW       (SW),
    .DBW      (8),
    .DBCYCLES (16)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .cfg_write  (cfg_write),
    .cfg_sel    (cfg_sel),
    .cfg_wdata  (cfg_wdata),
    .cfg_rdata  (cfg_rdata),
    .gpio_out   (gpio_out),
    .gpio_in    (gpio_in),
    .irq_clear  (irq_clear),
    .irq_status (irq_status),
    .irq        (irq),
    .pad_dout   (pad_dout),
    .pad_oen    (pad_oen),
    .pad_ie     (pad_ie),
    .pad_cfg    (pad_cfg),
    .pad_din    (pad_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [SW-1:0] sel, input logic [15:0] data);
    cfg_sel   = sel;
    cfg_wdata = data;
    cfg_write = 1'b1;
    step(1);
    cfg_write = 1'b0;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    nreset    = 1'b0;
    cfg_write = 1'b0;
    cfg_sel   = '0;
    cfg_wdata = '0;
    gpio_out  = '0;
    irq_clear = '0;
    pad_din   = '1;
    step(3);

    chk("rst_oen", 64'(pad_oen), 64'hFF);
    chk("rst_ie", 64'(pad_ie), 64'h0);
    chk("rst_dout", 64'(pad_dout), 64'h0);
    chk("rst_cfg", pad_cfg, 64'h0);
    chk("rst_gpio_in", 64'(gpio_in), 64'h0);
    chk("rst_status", 64'(irq_status), 64'h0);
    chk("rst_irq", 64'(irq), 64'h0);
    chk("rst_rdata", 64'(cfg_rdata), 64'h0);

    nreset = 1'b1;
    step(4);
    chk("dis_gpio_in", 64'(gpio_in), 64'h0);
    pad_din = 8'h04;

    // Pin 2 stays disabled; pad cfg forwarded, reserved bits dropped.
    wr(2, 16'hC0A5);
    cfg_sel = 2;
    #1;
    chk("p2_rdata", 64'(cfg_rdata), 64'h00A5);
    chk("p2_padcfg", 64'(pad_cfg[23:16]), 64'hA5);
    step(4);
    chk("p2_gpio_in", 64'(gpio_in[2]), 64'h0);

    // Pin 0 push-pull.
    wr(0, 16'h0200);
    cfg_sel = 0;
    #1;
    chk("p0_rdata", 64'(cfg_rdata), 64'h0200);
    chk("p0_oen", 64'(pad_oen[0]), 64'h0);
    gpio_out[0] = 1'b1;
    #1;
    chk("p0_dout1", 64'(pad_dout[0]), 64'h1);
    gpio_out[0] = 1'b0;
    #1;
    chk("p0_dout0", 64'(pad_dout[0]), 64'h0);

    // Pin 1 open-drain.
    wr(1, 16'h0300);
    gpio_out[1] = 1'b0;
    #1;
    chk("p1_od_dout", 64'(pad_dout[1]), 64'h0);
    chk("p1_od_oen0", 64'(pad_oen[1]), 64'h0);
    gpio_out[1] = 1'b1;
    #1;
    chk("p1_od_oen1", 64'(pad_oen[1]), 64'h1);
    chk("p1_od_dout1", 64'(pad_dout[1]), 64'h0);

    // Pin 3 input, rising edge, masked-in, no debounce.
    wr(3, 16'h2500);
    pad_din[3] = 1'b1;
    step(2);
    chk("p3_lat2", 64'(gpio_in[3]), 64'h0);
    step(1);
    chk("p3_lat3", 64'(gpio_in[3]), 64'h1);
    chk("p3_status", 64'(irq_status), 64'h08);
    chk("p3_irq", 64'(irq), 64'h1);
    irq_clear = 8'h08;
    step(1);
    irq_clear = '0;
    chk("p3_clr", 64'(irq_status), 64'h00);
    chk("p3_irq_clr", 64'(irq), 64'h0);
    pad_din[3] = 1'b0;
    step(4);
    chk("p3_fall_in", 64'(gpio_in[3]), 64'h0);
    chk("p3_fall_nost", 64'(irq_status), 64'h00);

    // Pin 4 debounce: short glitch rejected, long pulse accepted.
    wr(4, 16'h1D00);
    pad_din[4] = 1'b1;
    step(10);
    pad_din[4] = 1'b0;
    step(20);
    chk("p4_glitch_in", 64'(gpio_in[4]), 64'h0);
    chk("p4_glitch_st", 64'(irq_status), 64'h00);
    pad_din[4] = 1'b1;
    step(17);
    chk("p4_db17", 64'(gpio_in[4]), 64'h0);
    step(1);
    chk("p4_db18", 64'(gpio_in[4]), 64'h1);
    chk("p4_status", 64'(irq_status), 64'h10);
    chk("p4_irq_masked", 64'(irq), 64'h0);
    step(2);
    irq_clear = 8'h10;
    step(1);
    irq_clear = '0;
    chk("p4_clr", 64'(irq_status), 64'h00);

    // Pin 5: set and clear in the same cycle, set wins.
    wr(5, 16'h2D00);
    pad_din[5] = 1'b1;
    step(2);
    chk("p5_pre", 64'(gpio_in[5]), 64'h0);
    irq_clear = 8'h20;
    step(1);
    irq_clear = '0;
    chk("p5_setwins", 64'(irq_status), 64'h20);
    chk("p5_irq", 64'(irq), 64'h1);
    irq_clear = 8'h20;
    step(1);
    irq_clear = '0;
    chk("p5_clr", 64'(irq_status), 64'h00);

    // Out-of-range select: write dropped, read returns zero.
    wr(8, 16'h3FFF);
    cfg_sel = 8;
    #1;
    chk("oor_rdata", 64'(cfg_rdata), 64'h0);
    chk("oor_oen", 64'(pad_oen), 64'hFE);
    chk("oor_ie", 64'(pad_ie), 64'h3B);
    cfg_sel = 0;
    #1;
    chk("oor_p0_rdata", 64'(cfg_rdata), 64'h0200);

    // Reset mid-debounce on pin 4 discards the count.
    pad_din[4] = 1'b0;
    step(25);
    pad_din[4] = 1'b1;
    step(10);
    nreset = 1'b0;
    step(1);
    nreset = 1'b1;
    cfg_sel = 4;
    #1;
    chk("mrst_gpio_in", 64'(gpio_in), 64'h0);
    chk("mrst_status", 64'(irq_status), 64'h0);
    chk("mrst_rdata", 64'(cfg_rdata), 64'h0);
    chk("mrst_oen", 64'(pad_oen), 64'hFF);
    wr(4, 16'h1D00);
    step(17);
    chk("mrst_db17", 64'(gpio_in[4]), 64'h0);
    step(1);
    chk("mrst_db18", 64'(gpio_in[4]), 64'h1);
    chk("mrst_status4", 64'(irq_status), 64'h10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
